// File: rtl/fifo_nibble_packer.sv
// Read-side consumer for a 4-bit FIFO. It strobes single-cycle reads,
// opens the FIFO output enable only around a read, packs nibble pairs
// into bytes, hands the bytes out on a valid/ready handshake and counts
// the bytes that downstream accepts.
module fifo_nibble_packer #(
  parameter int          RD_LAT    = 1,         // rd-to-data latency, 1..4
  parameter bit          MSN_FIRST = 1'b1,      // 1: first nibble -> [7:4]
  parameter logic [15:0] CNT_INIT  = 16'h0000   // byte_count reset value (test preload hook)
) (
  input  logic        i_clk_in,
  input  logic        i_rst,
  input  logic        i_fifo_emp,
  input  logic [3:0]  i_fifo_data,
  output logic        o_fifo_rd,
  output logic        o_fifo_status,
  input  logic        i_flush,
  output logic [7:0]  o_out_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [15:0] o_byte_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_CAP  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  // WAIT lasts RD_LAT-1 cycles; the counter is loaded with one less than that
  // and WAIT exits when it reaches zero.
  localparam logic [1:0] WAIT_LOAD = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  // Place the first and second nibble of a pair according to MSN_FIRST.
  function automatic logic [7:0] pack_nibbles(input logic [3:0] first,
                                              input logic [3:0] second);
    logic [7:0] packed_byte;
    if (MSN_FIRST) begin
      packed_byte = {first, second};
    end else begin
      packed_byte = {second, first};
    end
    return packed_byte;
  endfunction

  state_t      r_state;
  logic [1:0]  r_wait_cnt;
  logic        r_have_nib;
  logic [3:0]  r_hold;
  logic [7:0]  r_out_data;
  logic        r_out_valid;
  logic        r_fifo_rd;
  logic        r_fifo_status;
  logic [15:0] r_byte_count;

  state_t      w_next_state;
  logic [1:0]  w_wait_cnt_next;
  logic        w_have_nib_next;
  logic [3:0]  w_hold_next;
  logic [7:0]  w_out_data_next;
  logic [15:0] w_byte_count_next;
  logic        w_bus_window_next;

  // Next-state and datapath-update logic for the read/pack/handshake sequence.
  always_comb begin
    w_next_state      = r_state;
    w_wait_cnt_next   = r_wait_cnt;
    w_have_nib_next   = r_have_nib;
    w_hold_next       = r_hold;
    w_out_data_next   = r_out_data;
    w_byte_count_next = r_byte_count;

    case (r_state)
      S_IDLE: begin
        // A waiting FIFO entry wins over a flush request.
        if (!i_fifo_emp) begin
          w_next_state = S_RD;
        end else if (i_flush && r_have_nib) begin
          w_next_state    = S_OUT;
          w_out_data_next = pack_nibbles(r_hold, 4'h0);
          w_have_nib_next = 1'b0;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RD: begin
        if (RD_LAT > 1) begin
          w_next_state    = S_WAIT;
          w_wait_cnt_next = WAIT_LOAD;
        end else begin
          w_next_state = S_CAP;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == 2'd0) begin
          w_next_state = S_CAP;
        end else begin
          w_wait_cnt_next = r_wait_cnt - 2'd1;
        end
      end
      S_CAP: begin
        if (!r_have_nib) begin
          w_hold_next     = i_fifo_data;
          w_have_nib_next = 1'b1;
          if (i_fifo_emp) begin
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_RD;
          end
        end else begin
          w_out_data_next = pack_nibbles(r_hold, i_fifo_data);
          w_have_nib_next = 1'b0;
          w_next_state    = S_OUT;
        end
      end
      S_OUT: begin
        if (i_out_ready) begin
          w_byte_count_next = r_byte_count + 16'd1;
          w_next_state      = S_IDLE;
        end else begin
          w_next_state = S_OUT;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    w_bus_window_next = (w_next_state == S_RD) || (w_next_state == S_WAIT) ||
                        (w_next_state == S_CAP);
  end

  // State and registered outputs; outputs are decoded from the next state so
  // they line up with the state they belong to.
  always_ff @(posedge i_clk_in) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= 2'd0;
      r_have_nib    <= 1'b0;
      r_hold        <= 4'h0;
      r_out_data    <= 8'h00;
      r_out_valid   <= 1'b0;
      r_fifo_rd     <= 1'b0;
      r_fifo_status <= 1'b1;
      r_byte_count  <= CNT_INIT;
    end else begin
      r_state       <= w_next_state;
      r_wait_cnt    <= w_wait_cnt_next;
      r_have_nib    <= w_have_nib_next;
      r_hold        <= w_hold_next;
      r_out_data    <= w_out_data_next;
      r_out_valid   <= (w_next_state == S_OUT);
      r_fifo_rd     <= (w_next_state == S_RD);
      r_fifo_status <= !w_bus_window_next;
      r_byte_count  <= w_byte_count_next;
    end
  end

  assign o_fifo_rd     = r_fifo_rd;
  assign o_fifo_status = r_fifo_status;
  assign o_out_data    = r_out_data;
  assign o_out_valid   = r_out_valid;
  assign o_byte_count  = r_byte_count;

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Bench for fifo_nibble_packer. Two instances: A (RD_LAT=1, MSN first) and
// B (RD_LAT=3, LSN first, byte counter preloaded to 16'hFFFF). Each has a
// queue-based FIFO model with the configured read latency.
module tb_fifo_nibble_packer;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic        a_emp, a_rd, a_status, a_flush, a_valid, a_ready;
  logic        b_emp, b_rd, b_status, b_flush, b_valid, b_ready;
  logic [3:0]  a_bus, b_bus;
  logic [3:0]  a_data, b_data;
  logic [7:0]  a_out, b_out;
  logic [15:0] a_cnt, b_cnt;

  // A released bus floats; model it as a fixed junk value.
  assign a_data = a_status ? 4'hE : a_bus;
  assign b_data = b_status ? 4'hE : b_bus;

  fifo_nibble_packer #(.RD_LAT(LAT_A), .MSN_FIRST(1'b1)) u_dut_a (
    .i_clk_in(clk), .i_rst(rst_a), .i_fifo_emp(a_emp), .i_fifo_data(a_data),
    .o_fifo_rd(a_rd), .o_fifo_status(a_status), .i_flush(a_flush),
    .o_out_data(a_out), .o_out_valid(a_valid), .i_out_ready(a_ready),
    .o_byte_count(a_cnt)
  );

  fifo_nibble_packer #(.RD_LAT(LAT_B), .MSN_FIRST(1'b0), .CNT_INIT(16'hFFFF)) u_dut_b (
    .i_clk_in(clk), .i_rst(rst_b), .i_fifo_emp(b_emp), .i_fifo_data(b_data),
    .o_fifo_rd(b_rd), .o_fifo_status(b_status), .i_flush(b_flush),
    .o_out_data(b_out), .o_out_valid(b_valid), .i_out_ready(b_ready),
    .o_byte_count(b_cnt)
  );

  int checks = 0;
  int passes = 0;

  // FIFO models
  logic [3:0] qa[$];
  logic [3:0] qb[$];
  logic [3:0] pva, pvb;
  int agea, ageb;
  int rda_pulses, rdb_pulses, rda_empty, rdb_empty;

  function automatic logic [7:0] pair_byte(input logic [3:0] first, input logic [3:0] second,
                                           input bit msn_first);
    int v;
    if (msn_first) v = int'(first) * 16 + int'(second);
    else           v = int'(second) * 16 + int'(first);
    return 8'(v);
  endfunction

  task automatic push_a(input logic [3:0] n);
    qa.push_back(n);
    a_emp = 1'b0;
  endtask

  task automatic push_b(input logic [3:0] n);
    qb.push_back(n);
    b_emp = 1'b0;
  endtask

  // Advance one clock; the FIFO models react to the strobes seen before the edge.
  task automatic tick();
    logic ra, rb;
    ra = a_rd;
    rb = b_rd;
    @(posedge clk);
    #1;
    if (ra === 1'b1) begin
      rda_pulses++;
      if (qa.size() == 0) rda_empty++;
      else begin pva = qa.pop_front(); agea = 0; end
    end else if (agea < 100) agea++;
    a_bus = (agea >= LAT_A - 1) ? pva : ~pva;
    a_emp = (qa.size() == 0);
    if (rb === 1'b1) begin
      rdb_pulses++;
      if (qb.size() == 0) rdb_empty++;
      else begin pvb = qb.pop_front(); ageb = 0; end
    end else if (ageb < 100) ageb++;
    b_bus = (ageb >= LAT_B - 1) ? pvb : ~pvb;
    b_emp = (qb.size() == 0);
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    tick(); tick();
    checks++; if (a_rd !== 1'b0) $display("FAIL reset_rd: got %b want 0", a_rd); else passes++;
    checks++; if (a_status !== 1'b1) $display("FAIL reset_status: got %b want 1", a_status); else passes++;
    checks++; if (a_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", a_valid); else passes++;
    checks++; if (a_out !== 8'h00) $display("FAIL reset_data: got %h want 00", a_out); else passes++;
    checks++; if (a_cnt !== 16'h0000) $display("FAIL reset_count: got %h want 0000", a_cnt); else passes++;
    checks++; if (b_status !== 1'b1) $display("FAIL reset_status_b: got %b want 1", b_status); else passes++;
    checks++; if (b_cnt !== 16'hFFFF) $display("FAIL reset_count_b: got %h want ffff", b_cnt); else passes++;
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
  endtask

  task automatic test_basic_pair();
    int first_valid, p0;
    logic [7:0]  got;
    logic [15:0] cnt0;
    a_ready = 1'b1; cnt0 = a_cnt; p0 = rda_pulses; first_valid = -1; got = 8'h00;
    push_a(4'h9); push_a(4'hD);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (a_valid === 1'b1 && first_valid < 0) begin first_valid = k; got = a_out; end
    end
    checks++; if (first_valid != 2 * (LAT_A + 1) + 1)
      $display("FAIL basic_latency: got %0d want %0d", first_valid, 2 * (LAT_A + 1) + 1); else passes++;
    checks++; if (got !== pair_byte(4'h9, 4'hD, 1'b1))
      $display("FAIL basic_data: got %h want %h", got, pair_byte(4'h9, 4'hD, 1'b1)); else passes++;
    checks++; if (rda_pulses - p0 != 2)
      $display("FAIL basic_rd_pulses: got %0d want 2", rda_pulses - p0); else passes++;
    checks++; if (a_cnt !== cnt0 + 16'd1)
      $display("FAIL basic_count: got %h want %h", a_cnt, cnt0 + 16'd1); else passes++;
  endtask

  task automatic test_latency_order();
    int rd_map, st0_map, first_valid, exp_rd, exp_st0;
    logic [7:0] got;
    b_ready = 1'b1; rd_map = 0; st0_map = 0; first_valid = -1; got = 8'h00;
    push_b(4'h3); push_b(4'hC);
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (b_rd === 1'b1) rd_map = rd_map | (1 << k);
      if (b_status === 1'b0) st0_map = st0_map | (1 << k);
      if (b_valid === 1'b1 && first_valid < 0) begin first_valid = k; got = b_out; end
    end
    exp_rd  = (1 << 1) | (1 << (2 + LAT_B));
    exp_st0 = ((1 << (2 * (LAT_B + 1) + 1)) - 1) & ~1;
    checks++; if (rd_map != exp_rd) $display("FAIL lat_rd_cycles: got %h want %h", rd_map, exp_rd); else passes++;
    checks++; if (st0_map != exp_st0) $display("FAIL lat_bus_window: got %h want %h", st0_map, exp_st0); else passes++;
    checks++; if (first_valid != 2 * (LAT_B + 1) + 1)
      $display("FAIL lat_valid_cycle: got %0d want %0d", first_valid, 2 * (LAT_B + 1) + 1); else passes++;
    checks++; if (got !== pair_byte(4'h3, 4'hC, 1'b0))
      $display("FAIL lat_data: got %h want %h", got, pair_byte(4'h3, 4'hC, 1'b0)); else passes++;
    checks++; if (b_cnt !== 16'h0000) $display("FAIL lat_count_wrap: got %h want 0000", b_cnt); else passes++;
  endtask

  task automatic test_backpressure();
    logic [3:0]  n[4];
    logic [7:0]  held;
    logic [15:0] cnt0;
    int p0;
    a_ready = 1'b0; cnt0 = a_cnt;
    for (int i = 0; i < 4; i++) begin n[i] = 4'($urandom_range(0, 15)); push_a(n[i]); end
    for (int k = 0; k < 30 && a_valid !== 1'b1; k++) tick();
    checks++; if (a_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", a_valid); else passes++;
    held = a_out; p0 = rda_pulses;
    checks++; if (held !== pair_byte(n[0], n[1], 1'b1))
      $display("FAIL bp_data: got %h want %h", held, pair_byte(n[0], n[1], 1'b1)); else passes++;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if (a_out !== held || a_valid !== 1'b1)
        $display("FAIL bp_hold: got %h/%b want %h/1", a_out, a_valid, held); else passes++;
    end
    checks++; if (rda_pulses != p0) $display("FAIL bp_no_reads: got %0d want %0d", rda_pulses, p0); else passes++;
    a_ready = 1'b1;
    tick();
    checks++; if (a_cnt !== cnt0 + 16'd1) $display("FAIL bp_count: got %h want %h", a_cnt, cnt0 + 16'd1); else passes++;
    checks++; if (a_valid !== 1'b0) $display("FAIL bp_valid_drop: got %b want 0", a_valid); else passes++;
    for (int k = 0; k < 30 && a_valid !== 1'b1; k++) tick();
    checks++; if (a_out !== pair_byte(n[2], n[3], 1'b1) || a_valid !== 1'b1)
      $display("FAIL bp_second: got %h/%b want %h/1", a_out, a_valid, pair_byte(n[2], n[3], 1'b1)); else passes++;
    tick();
    checks++; if (a_cnt !== cnt0 + 16'd2) $display("FAIL bp_count2: got %h want %h", a_cnt, cnt0 + 16'd2); else passes++;
  endtask

  task automatic test_flush();
    int seen;
    logic [15:0] cnt0;
    a_ready = 1'b1; a_flush = 1'b0; cnt0 = a_cnt; seen = 0;
    push_a(4'hB);
    for (int k = 0; k < 6; k++) begin tick(); if (a_valid === 1'b1) seen++; end
    checks++; if (seen != 0) $display("FAIL flush_odd_no_out: got %0d want 0", seen); else passes++;
    a_flush = 1'b1;
    tick();
    checks++; if (a_valid !== 1'b1 || a_out !== pair_byte(4'hB, 4'h0, 1'b1))
      $display("FAIL flush_data: got %h/%b want %h/1", a_out, a_valid, pair_byte(4'hB, 4'h0, 1'b1)); else passes++;
    tick();
    seen = 0;
    for (int k = 0; k < 5; k++) begin tick(); if (a_valid === 1'b1) seen++; end
    checks++; if (seen != 0) $display("FAIL flush_empty_ignored: got %0d want 0", seen); else passes++;
    checks++; if (a_cnt !== cnt0 + 16'd1) $display("FAIL flush_count: got %h want %h", a_cnt, cnt0 + 16'd1); else passes++;
    checks++; if (rda_empty != 0) $display("FAIL flush_rd_on_empty: got %0d want 0", rda_empty); else passes++;
    a_flush = 1'b0;
  endtask

  task automatic test_reset_mid_pair();
    logic [3:0] n[4];
    b_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin n[i] = 4'($urandom_range(0, 15)); push_b(n[i]); end
    for (int k = 0; k < 6; k++) tick();
    checks++; if (b_status !== 1'b0 || b_rd !== 1'b0)
      $display("FAIL rmp_in_wait: got status %b rd %b want 0 0", b_status, b_rd); else passes++;
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    checks++; if (b_status !== 1'b1 || b_rd !== 1'b0 || b_valid !== 1'b0)
      $display("FAIL rmp_after_reset: got status %b rd %b valid %b want 1 0 0", b_status, b_rd, b_valid); else passes++;
    checks++; if (b_cnt !== 16'hFFFF) $display("FAIL rmp_count_reset: got %h want ffff", b_cnt); else passes++;
    for (int k = 0; k < 30 && b_valid !== 1'b1; k++) tick();
    checks++; if (b_valid !== 1'b1 || b_out !== pair_byte(n[2], n[3], 1'b0))
      $display("FAIL rmp_clean_byte: got %h/%b want %h/1", b_out, b_valid, pair_byte(n[2], n[3], 1'b0)); else passes++;
    tick();
    checks++; if (b_cnt !== 16'h0000) $display("FAIL rmp_count_wrap: got %h want 0000", b_cnt); else passes++;
  endtask

  task automatic test_random_stream();
    localparam int N = 16;
    logic [3:0]  nibs[N];
    logic [7:0]  exp_q[$];
    logic [15:0] cnt0;
    int pushed, viol, cyc;
    cnt0 = a_cnt; pushed = 0; viol = 0; cyc = 0;
    for (int i = 0; i < N; i++) nibs[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < N; i += 2) exp_q.push_back(pair_byte(nibs[i], nibs[i + 1], 1'b1));
    while (exp_q.size() > 0 && cyc < 3000) begin
      a_ready = ($urandom_range(0, 3) != 0);
      if (a_valid === 1'b1 && a_ready === 1'b1) begin
        checks++; if (a_out !== exp_q[0])
          $display("FAIL rand_byte: got %h want %h", a_out, exp_q[0]); else passes++;
        void'(exp_q.pop_front());
      end
      if (pushed < N && $urandom_range(0, 2) == 0) begin push_a(nibs[pushed]); pushed++; end
      if (a_rd === 1'b1 && a_status === 1'b1) viol++;
      tick();
      cyc++;
    end
    tick();
    checks++; if (exp_q.size() != 0) $display("FAIL rand_timeout: got %0d bytes left want 0", exp_q.size()); else passes++;
    checks++; if (viol != 0) $display("FAIL rand_rd_bus_released: got %0d want 0", viol); else passes++;
    checks++; if (rda_empty != 0) $display("FAIL rand_rd_on_empty: got %0d want 0", rda_empty); else passes++;
    checks++; if (a_cnt !== cnt0 + 16'(N / 2))
      $display("FAIL rand_count: got %h want %h", a_cnt, cnt0 + 16'(N / 2)); else passes++;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    a_emp = 1'b1; b_emp = 1'b1; a_flush = 1'b0; b_flush = 1'b0;
    a_ready = 1'b0; b_ready = 1'b0; a_bus = 4'h0; b_bus = 4'h0;
    pva = 4'h0; pvb = 4'h0; agea = 100; ageb = 100;
    rda_pulses = 0; rdb_pulses = 0; rda_empty = 0; rdb_empty = 0;
    test_reset();
    test_basic_pair();
    test_latency_order();
    test_backpressure();
    test_flush();
    test_reset_mid_pair();
    test_random_stream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
